// File: rtl/mu0_mc.sv
// mu0_mc: multicycle MU0 accumulator core.
// Runs FETCH -> DECODE -> (MEM) against a single-port memory over a
// req/ack handshake, so memories with wait states are supported. The ISA is
// the MU0 accumulator set, extended with AND/OR/XOR and load-immediate.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   mem_req         transfer request, held until mem_ack
//   mem_we          1 = write (STO), 0 = read
//   mem_addr        transfer address (pc in FETCH, ir address field in MEM)
//   mem_wdata       write data (acc) for STO
//   mem_rdata       read data, sampled on the accepting edge
//   mem_ack         accepts the transfer on an edge where mem_req=1
//   pc, ir, acc     architectural state
//   halted          set once STP has been decoded; cleared only by reset
module mu0_mc #(
   parameter  int unsigned DATA_W = 16,
   localparam int unsigned ADDR_W = DATA_W - 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] acc,
   output logic              halted
);

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_DECODE,
      ST_MEM,
      ST_HALT
   } state_e;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_STO = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_JMP = 4'h4,
      OP_JGE = 4'h5,
      OP_JNE = 4'h6,
      OP_STP = 4'h7,
      OP_AND = 4'h8,
      OP_OR  = 4'h9,
      OP_XOR = 4'hA,
      OP_LDI = 4'hB
   } op_e;

   state_e            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_acc;
   logic              r_halted;

   logic [3:0]        w_op;
   logic [ADDR_W-1:0] w_addr;
   logic              w_sto;
   logic              w_busy;
   logic              w_accept;
   logic [DATA_W-1:0] w_alu;

   assign w_op   = r_ir[DATA_W-1 -: 4];
   assign w_addr = r_ir[ADDR_W-1:0];
   assign w_sto  = (w_op == OP_STO);

   // The request is decoded from the state and masked by reset: a transfer
   // in flight is dropped on the reset edge itself (a coincident ack is
   // never seen by the memory), and FETCH requests in the very first cycle
   // after reset is released.
   assign w_busy   = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !reset;
   assign w_accept = w_busy && mem_ack;

   always_comb begin
      mem_req   = w_busy;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_busy) begin
         if (r_state == ST_FETCH) begin
            mem_addr = r_pc;
         end else begin
            mem_addr = w_addr;
            mem_we   = w_sto;
            if (w_sto) begin
               mem_wdata = r_acc;
            end
         end
      end
   end

   always_comb begin
      w_alu = mem_rdata;
      case (w_op)
         OP_ADD:  w_alu = r_acc + mem_rdata;
         OP_SUB:  w_alu = r_acc - mem_rdata;
         OP_AND:  w_alu = r_acc & mem_rdata;
         OP_OR:   w_alu = r_acc | mem_rdata;
         OP_XOR:  w_alu = r_acc ^ mem_rdata;
         default: w_alu = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_FETCH;
         r_pc     <= '0;
         r_ir     <= '0;
         r_acc    <= '0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_accept) begin
                  r_ir    <= mem_rdata;
                  r_pc    <= r_pc + ADDR_W'(1);
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_state <= ST_FETCH;
               case (w_op)
                  OP_LDA, OP_STO, OP_ADD, OP_SUB,
                  OP_AND, OP_OR, OP_XOR: r_state <= ST_MEM;
                  OP_JMP: r_pc <= w_addr;
                  OP_JGE: if (!r_acc[DATA_W-1]) r_pc <= w_addr;
                  OP_JNE: if (r_acc != '0) r_pc <= w_addr;
                  OP_STP: begin
                     // pc already advanced past the STP; step back onto it
                     r_halted <= 1'b1;
                     r_pc     <= r_pc - ADDR_W'(1);
                     r_state  <= ST_HALT;
                  end
                  OP_LDI: r_acc <= DATA_W'(w_addr);
                  default: ;
               endcase
            end
            ST_MEM: begin
               if (w_accept) begin
                  if (!w_sto) begin
                     r_acc <= w_alu;
                  end
                  r_state <= ST_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   assign pc     = r_pc;
   assign ir     = r_ir;
   assign acc    = r_acc;
   assign halted = r_halted;

endmodule

// File: tb/tb_mu0_mc.sv
module tb_mu0_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- 16-bit instance and memory ----------------
   logic        rst16, req16, we16, ack16, halt16, hold16, ld16;
   logic [11:0] addr16, pc16, lda16;
   logic [15:0] wd16, rd16, ir16, acc16, ldd16;
   int unsigned wait16;
   int unsigned wc16 = 0;
   logic [15:0] m16 [0:4095];

   mu0_mc #(.DATA_W(16)) u16 (
      .clk(clk), .reset(rst16), .mem_req(req16), .mem_we(we16),
      .mem_addr(addr16), .mem_wdata(wd16), .mem_rdata(rd16), .mem_ack(ack16),
      .pc(pc16), .ir(ir16), .acc(acc16), .halted(halt16)
   );

   assign rd16  = m16[addr16];
   assign ack16 = hold16 ? 1'b0 : (wait16 == 0) ? 1'b1 : (req16 && wc16 == wait16);

   always @(posedge clk) begin
      if (ld16) m16[lda16] <= ldd16;
      if (req16 && ack16) begin
         wc16 <= 0;
         if (we16) m16[addr16] <= wd16;
      end else if (req16) begin
         wc16 <= wc16 + 1;
      end else begin
         wc16 <= 0;
      end
   end

   // bus must stay stable from a waiting cycle to the next one
   logic        pr16 = 1'b0;
   logic        pwe16;
   logic [11:0] pad16;
   logic [15:0] pwd16;
   int          stab_bad = 0;
   always @(posedge clk) begin
      if (pr16 && !rst16 && (!req16 || we16 != pwe16 || addr16 != pad16 || wd16 != pwd16))
         stab_bad <= stab_bad + 1;
      pr16  <= req16 && !ack16 && !rst16;
      pwe16 <= we16;
      pad16 <= addr16;
      pwd16 <= wd16;
   end

   // ---------------- 8-bit instance and memory ----------------
   logic       rst8, req8, we8, ack8, halt8, ld8;
   logic [3:0] addr8, pc8, lda8;
   logic [7:0] wd8, rd8, ir8, acc8, ldd8;
   logic [7:0] m8 [0:15];

   mu0_mc #(.DATA_W(8)) u8 (
      .clk(clk), .reset(rst8), .mem_req(req8), .mem_we(we8),
      .mem_addr(addr8), .mem_wdata(wd8), .mem_rdata(rd8), .mem_ack(ack8),
      .pc(pc8), .ir(ir8), .acc(acc8), .halted(halt8)
   );

   assign rd8  = m8[addr8];
   assign ack8 = 1'b1;

   always @(posedge clk) begin
      if (ld8) m8[lda8] <= ldd8;
      if (req8 && ack8 && we8) m8[addr8] <= wd8;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load16(input logic [11:0] a, input logic [15:0] d);
      ld16 = 1'b1; lda16 = a; ldd16 = d;
      step();
      ld16 = 1'b0;
   endtask

   task automatic load8(input logic [3:0] a, input logic [7:0] d);
      ld8 = 1'b1; lda8 = a; ldd8 = d;
      step();
      ld8 = 1'b0;
   endtask

   // reset edge, release, then count edges until halted (bounded)
   task automatic run16(output int n);
      rst16 = 1'b1; step(); rst16 = 1'b0;
      n = 0;
      while (!halt16 && n < 300) begin step(); n++; end
   endtask

   task automatic run8(output int n);
      rst8 = 1'b1; step(); rst8 = 1'b0;
      n = 0;
      while (!halt8 && n < 300) begin step(); n++; end
   endtask

   typedef struct {
      bit          w8;
      logic [3:0]  op;
      logic [15:0] a0;
      logic [15:0] opd;
      logic [15:0] exp;
      int          cyc;
      string       nm;
   } vec_t;

   vec_t vt [13];

   initial begin
      int n;
      rst16 = 1'b1; rst8 = 1'b1; hold16 = 1'b0; ld16 = 1'b0; ld8 = 1'b0;
      lda16 = '0; ldd16 = '0; lda8 = '0; ldd8 = '0; wait16 = 0;

      vt[0]  = '{1'b0, 4'h2, 16'hFFFF, 16'h0002, 16'h0001, 11, "add16"};
      vt[1]  = '{1'b0, 4'h3, 16'h0005, 16'h0007, 16'hFFFE, 11, "sub16"};
      vt[2]  = '{1'b0, 4'h8, 16'hF0F0, 16'h3C3C, 16'h3030, 11, "and16"};
      vt[3]  = '{1'b0, 4'h9, 16'hF000, 16'h000F, 16'hF00F, 11, "or16"};
      vt[4]  = '{1'b0, 4'hA, 16'hAAAA, 16'hFFFF, 16'h5555, 11, "xor16"};
      vt[5]  = '{1'b0, 4'h0, 16'h1111, 16'h1234, 16'h1234, 11, "lda16"};
      vt[6]  = '{1'b0, 4'hD, 16'h4321, 16'h9999, 16'h4321, 10, "nop16"};
      vt[7]  = '{1'b0, 4'hB, 16'h4321, 16'h9999, 16'h0101, 10, "ldi16"};
      vt[8]  = '{1'b1, 4'h8, 16'h00F0, 16'h003C, 16'h0030, 11, "and8"};
      vt[9]  = '{1'b1, 4'h9, 16'h00A0, 16'h0005, 16'h00A5, 11, "or8"};
      vt[10] = '{1'b1, 4'hA, 16'h00FF, 16'h005A, 16'h00A5, 11, "xor8"};
      vt[11] = '{1'b1, 4'h2, 16'h00F0, 16'h0020, 16'h0010, 11, "add8"};
      vt[12] = '{1'b1, 4'h3, 16'h0000, 16'h0001, 16'h00FF, 11, "sub8"};

      step();
      chk("rst_req16", {31'd0, req16}, 32'd0);
      chk("rst_pc16", {20'd0, pc16}, 32'd0);
      chk("rst_acc16", {16'd0, acc16}, 32'd0);
      chk("rst_halt16", {31'd0, halt16}, 32'd0);

      // table: LDA a0 / <op> operand / STO result / STP
      for (int i = 0; i < 13; i++) begin
         if (!vt[i].w8) begin
            rst16 = 1'b1;
            load16(12'h000, 16'h0100);
            load16(12'h001, {vt[i].op, 12'h101});
            load16(12'h002, 16'h1102);
            load16(12'h003, 16'h7000);
            load16(12'h100, vt[i].a0);
            load16(12'h101, vt[i].opd);
            load16(12'h102, 16'hBEEF);
            run16(n);
            chk({vt[i].nm, "_cyc"}, n, vt[i].cyc);
            chk({vt[i].nm, "_acc"}, {16'd0, acc16}, {16'd0, vt[i].exp});
            chk({vt[i].nm, "_mem"}, {16'd0, m16[12'h102]}, {16'd0, vt[i].exp});
         end else begin
            rst8 = 1'b1;
            load8(4'h0, 8'h0C);
            load8(4'h1, {vt[i].op, 4'hD});
            load8(4'h2, 8'h1E);
            load8(4'h3, 8'h70);
            load8(4'hC, vt[i].a0[7:0]);
            load8(4'hD, vt[i].opd[7:0]);
            load8(4'hE, 8'hEE);
            run8(n);
            chk({vt[i].nm, "_cyc"}, n, vt[i].cyc);
            chk({vt[i].nm, "_acc"}, {24'd0, acc8}, {16'd0, vt[i].exp});
            chk({vt[i].nm, "_mem"}, {24'd0, m8[4'hE]}, {16'd0, vt[i].exp});
         end
      end

      // reference program, zero-wait then 2 wait states per transfer
      for (int w = 0; w < 2; w++) begin
         rst16 = 1'b1;
         wait16 = (w == 0) ? 0 : 2;
         load16(12'h000, 16'h0010);
         load16(12'h001, 16'h2011);
         load16(12'h002, 16'h1012);
         load16(12'h003, 16'h7000);
         load16(12'h010, 16'h0005);
         load16(12'h011, 16'h0003);
         load16(12'h012, 16'h0000);
         run16(n);
         chk("prog_cyc", n, (w == 0) ? 11 : 25);
         chk("prog_mem", {16'd0, m16[12'h012]}, 32'h0008);
         chk("prog_pc", {20'd0, pc16}, 32'h003);
         chk("prog_acc", {16'd0, acc16}, 32'h0008);
         chk("prog_ir", {16'd0, ir16}, 32'h7000);
         repeat (3) step();
         chk("halt_noreq", {31'd0, req16}, 32'd0);
         chk("halt_pc", {20'd0, pc16}, 32'h003);
         chk("halt_stays", {31'd0, halt16}, 32'd1);
      end
      chk("wait_stable", stab_bad, 0);
      wait16 = 0;

      // countdown: LDI 3; loop: SUB M[20]=1; JNE loop; STP
      rst16 = 1'b1;
      load16(12'h000, 16'hB003);
      load16(12'h001, 16'h3020);
      load16(12'h002, 16'h6001);
      load16(12'h003, 16'h7000);
      load16(12'h020, 16'h0001);
      run16(n);
      chk("loop_cyc", n, 19);
      chk("loop_acc", {16'd0, acc16}, 32'h0000);
      chk("loop_pc", {20'd0, pc16}, 32'h003);

      // SUB from 0 -> FFFF, JGE must not be taken
      rst16 = 1'b1;
      load16(12'h000, 16'h3020);
      load16(12'h001, 16'h5004);
      load16(12'h002, 16'h7000);
      load16(12'h004, 16'hB123);
      load16(12'h005, 16'h7000);
      run16(n);
      chk("jge_cyc", n, 7);
      chk("jge_acc", {16'd0, acc16}, 32'hFFFF);
      chk("jge_pc", {20'd0, pc16}, 32'h002);

      // reset while a STO waits in MEM
      rst16 = 1'b1;
      load16(12'h000, 16'hB055);
      load16(12'h001, 16'h1030);
      load16(12'h002, 16'h7000);
      load16(12'h030, 16'hDEAD);
      step(); rst16 = 1'b0;
      step(); step(); step();
      hold16 = 1'b1;
      step();
      chk("sto_req", {31'd0, req16}, 32'd1);
      chk("sto_we", {31'd0, we16}, 32'd1);
      chk("sto_addr", {20'd0, addr16}, 32'h030);
      chk("sto_wdata", {16'd0, wd16}, 32'h0055);
      step(); step();
      chk("sto_held", {31'd0, req16}, 32'd1);
      rst16 = 1'b1; hold16 = 1'b0;
      step();
      chk("rstmid_req", {31'd0, req16}, 32'd0);
      chk("rstmid_pc", {20'd0, pc16}, 32'd0);
      chk("rstmid_ir", {16'd0, ir16}, 32'd0);
      chk("rstmid_acc", {16'd0, acc16}, 32'd0);
      chk("rstmid_mem", {16'd0, m16[12'h030]}, 32'hDEAD);
      rst16 = 1'b0;
      #1;
      chk("restart_req", {31'd0, req16}, 32'd1);
      chk("restart_addr", {20'd0, addr16}, 32'd0);
      n = 0;
      while (!halt16 && n < 300) begin step(); n++; end
      chk("restart_cyc", n, 7);
      chk("restart_mem", {16'd0, m16[12'h030]}, 32'h0055);

      // opcode D behaves as a 2-cycle NOP
      rst16 = 1'b1;
      load16(12'h000, 16'hB077);
      load16(12'h001, 16'hD5A5);
      load16(12'h002, 16'h7000);
      step(); rst16 = 1'b0;
      step(); step(); step();
      chk("nop_dec_req", {31'd0, req16}, 32'd0);
      chk("nop_ir", {16'd0, ir16}, 32'hD5A5);
      step();
      chk("nop_next_req", {31'd0, req16}, 32'd1);
      chk("nop_next_addr", {20'd0, addr16}, 32'h002);
      chk("nop_acc", {16'd0, acc16}, 32'h0077);
      step(); step();
      chk("nop_halt", {31'd0, halt16}, 32'd1);
      chk("nop_pc", {20'd0, pc16}, 32'h002);

      // 8-bit: JMP 0xF at 0xE, fetch at 0xF wraps pc to 0
      rst8 = 1'b1;
      load8(4'h0, 8'h65);
      load8(4'h1, 8'h4E);
      load8(4'hE, 8'h4F);
      load8(4'hF, 8'hBA);
      load8(4'h5, 8'h70);
      step(); rst8 = 1'b0;
      repeat (7) step();
      chk("wrap_pc", {28'd0, pc8}, 32'h0);
      chk("wrap_ir", {24'd0, ir8}, 32'hBA);
      n = 7;
      while (!halt8 && n < 300) begin step(); n++; end
      chk("wrap_cyc", n, 12);
      chk("wrap_acc", {24'd0, acc8}, 32'h0A);
      chk("wrap_stp_pc", {28'd0, pc8}, 32'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
